// File: rtl/game_sequencer.sv
// game_sequencer: central game-flow controller for the snake game.
// Paces snake steps from frame_start, judges wall/fruit collisions two cycles
// after each step, and owns lives, score and the IDLE/PLAY/HIT/OVER state.
// All datapath commands leave as registered one-cycle pulses.
// Optional build macro GAME_PAUSE_EN adds a pause_btn input that freezes pacing.
module game_sequencer #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int MAX_LIVES       = 3,
  parameter int HIT_HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        start_btn,
`ifdef GAME_PAUSE_EN
  input  logic        pause_btn,
`endif
  input  logic        wall_hit,
  input  logic        fruit_hit,
  input  logic [1:0]  fruit_type,
  output logic        move_step,
  output logic        respawn,
  output logic        fruit_ack,
  output logic        grow,
  output logic        shrink,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HC_W = (HIT_HOLD_FRAMES > 1) ? $clog2(HIT_HOLD_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [HC_W-1:0] HC_LAST   = HC_W'(HIT_HOLD_FRAMES - 1);
  localparam logic [2:0]      LIVES_MAX = 3'(MAX_LIVES);

  state_t            st_q, st_nxt;
  logic [2:0]        lives_q, lives_nxt;
  logic [15:0]       score_q, score_nxt;
  logic [FC_W-1:0]   fc_q, fc_nxt;
  logic [HC_W-1:0]   hc_q, hc_nxt;
  logic              move_q, move_nxt;
  logic              respawn_q, respawn_nxt;
  logic              ack_q, ack_nxt;
  logic              grow_q, grow_nxt;
  logic              shrink_q, shrink_nxt;
  logic              pend_q, pend_nxt;
  logic              start_prev;
  logic              start_edge;
  logic              step_due;
  logic              sample;
  logic              pace_en;
  // Check pipeline: a step issued in cycle T is judged in cycle T+2.
  logic              vld_p1, vld_p2;

  function automatic logic [15:0] sat_inc_score(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2:0] sat_inc_lives(input logic [2:0] v);
    return (v >= LIVES_MAX) ? LIVES_MAX : v + 3'd1;
  endfunction

  assign start_edge = start_btn & ~start_prev;
  assign sample     = vld_p2 & (st_q == ST_PLAY);

`ifdef GAME_PAUSE_EN
  logic pause_prev, paused_q, paused_nxt, pause_edge;
  assign pause_edge = pause_btn & ~pause_prev;
  assign pace_en    = ~paused_q;
`else
  assign pace_en    = 1'b1;
`endif

  // Next-state and command-pulse decode for the game flow.
  always_comb begin
    st_nxt      = st_q;
    lives_nxt   = lives_q;
    score_nxt   = score_q;
    fc_nxt      = fc_q;
    hc_nxt      = hc_q;
    pend_nxt    = 1'b0;
    move_nxt    = 1'b0;
    respawn_nxt = 1'b0;
    ack_nxt     = 1'b0;
    grow_nxt    = 1'b0;
    shrink_nxt  = 1'b0;
    step_due    = 1'b0;
`ifdef GAME_PAUSE_EN
    // The pause flag only survives while the game stays in PLAY.
    paused_nxt  = (st_q == ST_PLAY) ? paused_q : 1'b0;
`endif
    case (st_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          st_nxt      = ST_PLAY;
          lives_nxt   = LIVES_MAX;
          score_nxt   = '0;
          fc_nxt      = '0;
          hc_nxt      = '0;
          respawn_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
`ifdef GAME_PAUSE_EN
        if (pause_edge) paused_nxt = ~paused_q;
`endif
        // A step deferred last cycle (collided with fruit pulses) goes out now.
        step_due = pend_q;
        if (frame_start && pace_en) begin
          if (fc_q == FC_LAST) begin
            fc_nxt   = '0;
            step_due = 1'b1;
          end else begin
            fc_nxt   = fc_q + FC_W'(1);
          end
        end
        if (sample && wall_hit) begin
          // Wall wins over fruit; leaving PLAY drops any step due this cycle.
          hc_nxt = '0;
          if (lives_q > 3'd1) begin
            lives_nxt = lives_q - 3'd1;
            st_nxt    = ST_HIT;
          end else begin
            lives_nxt = '0;
            st_nxt    = ST_OVER;
          end
`ifdef GAME_PAUSE_EN
          paused_nxt = 1'b0;
`endif
        end else if (sample && fruit_hit) begin
          ack_nxt   = 1'b1;
          score_nxt = sat_inc_score(score_q);
          case (fruit_type)
            2'b01:   grow_nxt   = 1'b1;
            2'b10:   shrink_nxt = 1'b1;
            2'b11:   lives_nxt  = sat_inc_lives(lives_q);
            default: ;
          endcase
          // Keep move_step out of the fruit pulse cycle.
          pend_nxt = step_due;
        end else begin
          move_nxt = step_due;
        end
      end
      ST_HIT: begin
        if (frame_start) begin
          if (hc_q == HC_LAST) begin
            hc_nxt      = '0;
            fc_nxt      = '0;
            respawn_nxt = 1'b1;
            st_nxt      = ST_PLAY;
          end else begin
            hc_nxt      = hc_q + HC_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // State, counters, pulse outputs and check pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      lives_q    <= LIVES_MAX;
      score_q    <= '0;
      fc_q       <= '0;
      hc_q       <= '0;
      move_q     <= 1'b0;
      respawn_q  <= 1'b0;
      ack_q      <= 1'b0;
      grow_q     <= 1'b0;
      shrink_q   <= 1'b0;
      pend_q     <= 1'b0;
      start_prev <= 1'b1;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
`ifdef GAME_PAUSE_EN
      pause_prev <= 1'b1;
      paused_q   <= 1'b0;
`endif
    end else begin
      st_q       <= st_nxt;
      lives_q    <= lives_nxt;
      score_q    <= score_nxt;
      fc_q       <= fc_nxt;
      hc_q       <= hc_nxt;
      move_q     <= move_nxt;
      respawn_q  <= respawn_nxt;
      ack_q      <= ack_nxt;
      grow_q     <= grow_nxt;
      shrink_q   <= shrink_nxt;
      pend_q     <= pend_nxt;
      start_prev <= start_btn;
      vld_p1     <= move_q;
      vld_p2     <= vld_p1;
`ifdef GAME_PAUSE_EN
      pause_prev <= pause_btn;
      paused_q   <= paused_nxt;
`endif
    end
  end

  assign move_step = move_q;
  assign respawn   = respawn_q;
  assign fruit_ack = ack_q;
  assign grow      = grow_q;
  assign shrink    = shrink_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign state     = st_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: a directed cycle table, a few
// hand-written multi-cycle sequences, then random stimulus against a model.
module tb_game_sequencer;

  localparam int FPS = 4;
  localparam int ML  = 3;
  localparam int HHF = 2;

  localparam logic [4:0] P0   = 5'b00000;
  localparam logic [4:0] P_MV = 5'b10000;
  localparam logic [4:0] P_RS = 5'b01000;
  localparam logic [4:0] P_AK = 5'b00100;
  localparam logic [4:0] P_GR = 5'b00010;

  logic        clk = 1'b0;
  logic        reset, frame_start, start_btn, wall_hit, fruit_hit;
  logic [1:0]  fruit_type;
`ifdef GAME_PAUSE_EN
  logic        pause_btn = 1'b0;
`endif
  logic        move_step, respawn, fruit_ack, grow, shrink;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [1:0]  state;
  logic [4:0]  pv;

  assign pv = {move_step, respawn, fruit_ack, grow, shrink};

  game_sequencer #(.FRAMES_PER_STEP(FPS), .MAX_LIVES(ML), .HIT_HOLD_FRAMES(HHF)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .start_btn(start_btn),
`ifdef GAME_PAUSE_EN
    .pause_btn(pause_btn),
`endif
    .wall_hit(wall_hit), .fruit_hit(fruit_hit), .fruit_type(fruit_type),
    .move_step(move_step), .respawn(respawn), .fruit_ack(fruit_ack),
    .grow(grow), .shrink(shrink), .lives(lives), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic tick(input bit r, s, f, w, h, input logic [1:0] t);
    reset = r; start_btn = s; frame_start = f; wall_hit = w; fruit_hit = h; fruit_type = t;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, s, f, w, h;
    logic [1:0] t;
    int est, elv, esc;
    logic [4:0] epl;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, s, f, w, h, input logic [1:0] t,
                     input int est, elv, esc, input logic [4:0] epl);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.w = w; v.h = h; v.t = t;
    v.est = est; v.elv = elv; v.esc = esc; v.epl = epl;
    tbl.push_back(v);
  endtask

  // Four frame_starts in PLAY: the fourth produces a move_step, then the
  // two quiet cycles of the datapath latency.
  task automatic add_step(input int lv, sc);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 1, lv, sc, P0);
    add(0, 1, 1, 0, 0, 0, 1, lv, sc, P_MV);
    add(0, 1, 0, 0, 0, 0, 1, lv, sc, P0);
    add(0, 1, 0, 0, 0, 0, 1, lv, sc, P0);
  endtask

  // Reference model: game rules with plain integers and a queue of the
  // absolute edge numbers at which collision flags are to be judged.
  int m_state, m_lives, m_score, m_frames, m_hold, ek;
  bit m_sprev, m_defer;
  logic [4:0] m_pl;
  int checks[$];

  task automatic model_edge(input bit r, s, f, w, h, input logic [1:0] t);
    bit edge_s, smp, step;
    ek++;
    m_pl = '0;
    if (r) begin
      m_state = 0; m_lives = ML; m_score = 0; m_frames = 0; m_hold = 0;
      m_sprev = 1; m_defer = 0; checks.delete();
      return;
    end
    edge_s = s && !m_sprev;
    m_sprev = s;
    smp = 0;
    if (checks.size() > 0 && checks[0] == ek) begin
      void'(checks.pop_front());
      smp = (m_state == 1);
    end
    step = 0;
    case (m_state)
      0, 3: if (edge_s) begin
        m_state = 1; m_lives = ML; m_score = 0; m_frames = 0; m_hold = 0; m_defer = 0;
        m_pl = P_RS;
      end
      1: begin
        step = m_defer;
        m_defer = 0;
        if (f) begin
          m_frames++;
          if (m_frames == FPS) begin m_frames = 0; step = 1; end
        end
        if (smp && w) begin
          if (m_lives > 1) begin m_lives--; m_state = 2; m_hold = 0; end
          else begin m_lives = 0; m_state = 3; end
        end else if (smp && h) begin
          m_pl[2] = 1;
          if (m_score < 65535) m_score++;
          if (t == 2'd1) m_pl[1] = 1;
          else if (t == 2'd2) m_pl[0] = 1;
          else if (t == 2'd3 && m_lives < ML) m_lives++;
          m_defer = step;
        end else if (step) begin
          m_pl[4] = 1;
          checks.push_back(ek + 3);
        end
      end
      default: if (f) begin
        m_hold++;
        if (m_hold == HHF) begin m_hold = 0; m_frames = 0; m_pl[3] = 1; m_state = 1; end
      end
    endcase
  endtask

  task automatic mtick(input bit r, s, f, w, h, input logic [1:0] t);
    tick(r, s, f, w, h, t);
    model_edge(r, s, f, w, h, t);
    chk($sformatf("rnd%0d state", ek), int'(state), m_state);
    chk($sformatf("rnd%0d lives", ek), int'(lives), m_lives);
    chk($sformatf("rnd%0d score", ek), int'(score), m_score);
    chk($sformatf("rnd%0d pulses", ek), int'(pv), int'(m_pl));
  endtask

  initial begin
    int moves;
    int gap;
    bit s;
    bit r, f, w, h;
    logic [1:0] t;

    // Directed game: start, two fruits, two walls with HIT/respawn, game over.
    add(1, 0, 0, 0, 0, 0, 0, 3, 0, P0);
    add(0, 0, 0, 0, 0, 0, 0, 3, 0, P0);
    add(0, 1, 0, 0, 0, 0, 1, 3, 0, P_RS);
    add(0, 1, 0, 0, 0, 0, 1, 3, 0, P0);
    for (int k = 0; k < 3; k++) add(0, 1, 1, 0, 0, 0, 1, 3, 0, P0);
    add(0, 1, 1, 0, 0, 0, 1, 3, 0, P_MV);
    add(0, 1, 0, 0, 1, 3, 1, 3, 0, P0);          // fruit outside sample cycle
    add(0, 1, 0, 0, 1, 3, 1, 3, 0, P0);
    add(0, 1, 0, 0, 1, 3, 1, 3, 1, P_AK);        // life fruit at full lives
    add(0, 0, 0, 0, 0, 0, 1, 3, 1, P0);
    add(0, 1, 1, 0, 0, 0, 1, 3, 1, P0);          // start edge in PLAY ignored
    add(0, 1, 1, 0, 0, 0, 1, 3, 1, P0);
    add(0, 1, 1, 0, 0, 0, 1, 3, 1, P0);
    add(0, 1, 1, 0, 0, 0, 1, 3, 1, P_MV);
    add(0, 1, 0, 1, 0, 0, 1, 3, 1, P0);          // wall outside sample cycle
    add(0, 1, 0, 0, 0, 0, 1, 3, 1, P0);
    add(0, 1, 0, 0, 1, 1, 1, 3, 2, P_AK | P_GR); // grow fruit
    add(0, 1, 0, 0, 0, 0, 1, 3, 2, P0);
    add_step(3, 2);
    add(0, 1, 0, 1, 0, 0, 2, 2, 2, P0);          // wall, lives 3 -> 2
    add(0, 1, 1, 0, 0, 0, 2, 2, 2, P0);
    add(0, 1, 1, 0, 0, 0, 1, 2, 2, P_RS);
    add_step(2, 2);
    add(0, 1, 0, 1, 1, 1, 2, 1, 2, P0);          // wall + fruit: wall wins
    add(0, 1, 1, 0, 0, 0, 2, 1, 2, P0);
    add(0, 1, 1, 0, 0, 0, 1, 1, 2, P_RS);
    add_step(1, 2);
    add(0, 1, 0, 1, 0, 0, 3, 0, 2, P0);          // last life lost
    add(0, 1, 0, 0, 1, 3, 3, 0, 2, P0);

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].w, tbl[i].h, tbl[i].t);
      chk($sformatf("row%0d state", i), int'(state), tbl[i].est);
      chk($sformatf("row%0d lives", i), int'(lives), tbl[i].elv);
      chk($sformatf("row%0d score", i), int'(score), tbl[i].esc);
      chk($sformatf("row%0d pulses", i), int'(pv), int'(tbl[i].epl));
    end

    // OVER holds through 20 frames with no step.
    moves = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, 1, 1, 0, 0, 0);
      moves += int'(move_step);
      for (int j = 0; j < 3; j++) begin
        tick(0, 1, 0, 1, 1, 1);
        moves += int'(move_step);
      end
    end
    chk("over_moves", moves, 0);
    chk("over_state", int'(state), 3);
    chk("over_lives", int'(lives), 0);
    chk("over_score", int'(score), 2);

    // New start edge from OVER.
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    chk("restart_state", int'(state), 1);
    chk("restart_lives", int'(lives), 3);
    chk("restart_score", int'(score), 0);
    chk("restart_pulses", int'(pv), int'(P_RS));

    // Reset lands one cycle after a step whose check would see a wall.
    for (int k = 0; k < 4; k++) tick(0, 1, 1, 0, 0, 0);
    chk("pre_reset_move", int'(move_step), 1);
    tick(1, 1, 0, 1, 0, 0);
    chk("rst_state", int'(state), 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 1, 0, 0);
      chk($sformatf("post_rst%0d state", k), int'(state), 0);
      chk($sformatf("post_rst%0d lives", k), int'(lives), 3);
    end
    // Start button was held through reset: still idle until re-pressed.
    tick(0, 0, 0, 0, 0, 0);
    chk("release_state", int'(state), 0);
    tick(0, 1, 0, 0, 0, 0);
    chk("repress_state", int'(state), 1);
    chk("repress_pulses", int'(pv), int'(P_RS));

    // Random stimulus against the model.
    ek = 0;
    s = 0;
    gap = 0;
    mtick(1, 0, 0, 0, 0, 0);
    mtick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) s = ~s;
      f = 0;
      if (gap == 0) begin
        f = 1;
        gap = $urandom_range(5, 9);
      end else begin
        gap--;
      end
      w = ($urandom_range(0, 5) == 0);
      h = ($urandom_range(0, 2) == 0);
      t = 2'($urandom_range(0, 3));
      mtick(r, s, f, w, h, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
